freq_step_ctrl: RTL and testbench

- Front-panel frequency controller for the function-generator top level.
- Synchronises and debounces the Bt_Plus / Bt_Minus push-buttons and adds hold-to-auto-repeat.
- Keeps a saturating frequency step index and drives the phase increment shared by the sine, saw, triangle and square slow-wave generators.
- Sits between the board buttons and the wave datapath; runs on sysclk (50 MHz).

---
 rtl/freq_ctrl_pkg.sv | 31 +++
 rtl/freq_step_ctrl_if.sv | 24 ++
 rtl/btn_debounce.sv | 38 +++
 rtl/freq_step_ctrl.sv | 164 ++++++++++++++++
 tb/tb_freq_step_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/freq_ctrl_pkg.sv
// Shared types and 50 MHz timing defaults for the front-panel frequency controller.
// Timer width is derived from the longest interval any counter has to hold.
package freq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2,
      LOCK   = 2'd3
   } fsm_state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam int DEF_DEBOUNCE_CYC     = 500000;
   localparam int DEF_REPEAT_DELAY_CYC = 2500000;
   localparam int DEF_REPEAT_RATE_CYC  = 1000000;

   function automatic int timer_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

   localparam int TIMER_W = timer_w(DEF_REPEAT_DELAY_CYC, DEF_DEBOUNCE_CYC, 0);

endpackage

// File: rtl/freq_step_ctrl_if.sv
// Button inputs and step/phase-increment outputs of the frequency controller.
// master = board/button side, slave = controller.
interface freq_step_ctrl_if #(
   parameter int STEP_W = 4,
   parameter int INC_W  = 16
);
   logic              Bt_Plus;
   logic              Bt_Minus;
   logic [STEP_W-1:0] step_idx;
   logic [INC_W-1:0]  phase_inc;
   logic              step_pulse;
   logic              at_min;
   logic              at_max;

   modport master (
      output Bt_Plus, Bt_Minus,
      input  step_idx, phase_inc, step_pulse, at_min, at_max
   );

   modport slave (
      input  Bt_Plus, Bt_Minus,
      output step_idx, phase_inc, step_pulse, at_min, at_max
   );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// The level follows the input after DEBOUNCE_CYC+2 edges; shorter glitches are dropped.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int CNT_W        = 19
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         // The edge that would bring the count to DEBOUNCE_CYC flips the level instead.
         if (sync[1] != level) begin
            if (cnt == CNT_LAST) begin
               level <= ~level;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/freq_step_ctrl.sv
// Debounced Plus/Minus buttons with hold-to-repeat driving a saturating step index and phase increment.
// First step lands DEBOUNCE_CYC+3 edges after the raw press is first sampled.
module freq_step_ctrl
   import freq_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
   parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
   parameter int STEP_W           = 4,
   parameter int NUM_STEPS        = 16,
   parameter int RESET_STEP       = 0,
   parameter int INC_W            = 16,
   parameter int INC_UNIT         = 64
) (
   input logic             sysclk,
   input logic             reset,
   freq_step_ctrl_if.slave bus
);
   localparam int TMR_W = timer_w(REPEAT_DELAY_CYC, DEBOUNCE_CYC, REPEAT_RATE_CYC);
   localparam int DB_W  = timer_w(DEBOUNCE_CYC, 1, 1);

   localparam logic [STEP_W-1:0] RST_IDX  = STEP_W'(RESET_STEP);
   localparam logic [STEP_W-1:0] TOP_IDX  = STEP_W'(NUM_STEPS - 1);
   localparam logic [TMR_W-1:0]  DELAY_LD = TMR_W'(REPEAT_DELAY_CYC);
   localparam logic [TMR_W-1:0]  RATE_LD  = TMR_W'(REPEAT_RATE_CYC);

   function automatic logic [INC_W-1:0] inc_of(input logic [STEP_W-1:0] idx);
      logic [31:0] prod;
      prod = (32'(idx) + 32'd1) * 32'(INC_UNIT);
      return prod[INC_W-1:0];
   endfunction

   logic plus_lvl;
   logic minus_lvl;

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (DB_W)
   ) u_db_plus (
      .clk   (sysclk),
      .rst_n (reset),
      .btn   (bus.Bt_Plus),
      .level (plus_lvl)
   );

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (DB_W)
   ) u_db_minus (
      .clk   (sysclk),
      .rst_n (reset),
      .btn   (bus.Bt_Minus),
      .level (minus_lvl)
   );

   fsm_state_t        state, state_nxt;
   dir_t              dir, dir_nxt, step_dir;
   logic [TMR_W-1:0]  timer, timer_nxt;
   logic              step_req;
   logic              active_lvl, other_lvl;

   logic [STEP_W-1:0] idx_q, idx_nxt;
   logic [INC_W-1:0]  inc_q;
   logic              pulse_q, min_q, max_q;
   logic              do_step;

   assign active_lvl = (dir == DIR_UP) ? plus_lvl  : minus_lvl;
   assign other_lvl  = (dir == DIR_UP) ? minus_lvl : plus_lvl;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         dir   <= DIR_UP;
         timer <= '0;
      end else begin
         state <= state_nxt;
         dir   <= dir_nxt;
         timer <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      timer_nxt = timer;
      step_req  = 1'b0;
      step_dir  = dir;
      case (state)
         IDLE: begin
            if (plus_lvl && minus_lvl) begin
               state_nxt = LOCK;
            end else if (plus_lvl || minus_lvl) begin
               step_req  = 1'b1;
               step_dir  = plus_lvl ? DIR_UP : DIR_DOWN;
               dir_nxt   = step_dir;
               timer_nxt = DELAY_LD;
               state_nxt = HOLD;
            end
         end
         HOLD, REPEAT: begin
            // Release wins over a conflicting press; a conflict wins over a due repeat.
            if (!active_lvl) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (other_lvl) begin
               state_nxt = LOCK;
               timer_nxt = '0;
            end else if (timer <= TMR_W'(1)) begin
               step_req  = 1'b1;
               timer_nxt = RATE_LD;
               state_nxt = REPEAT;
            end else begin
               timer_nxt = timer - TMR_W'(1);
            end
         end
         LOCK: begin
            if (!plus_lvl && !minus_lvl) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   always_comb begin
      idx_nxt = idx_q;
      do_step = 1'b0;
      if (step_req) begin
         if (step_dir == DIR_UP && idx_q != TOP_IDX) begin
            idx_nxt = idx_q + STEP_W'(1);
            do_step = 1'b1;
         end else if (step_dir == DIR_DOWN && idx_q != '0) begin
            idx_nxt = idx_q - STEP_W'(1);
            do_step = 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         idx_q   <= RST_IDX;
         inc_q   <= inc_of(RST_IDX);
         pulse_q <= 1'b0;
         min_q   <= (RST_IDX == '0);
         max_q   <= (RST_IDX == TOP_IDX);
      end else begin
         pulse_q <= do_step;
         if (do_step) begin
            idx_q <= idx_nxt;
            inc_q <= inc_of(idx_nxt);
            min_q <= (idx_nxt == '0);
            max_q <= (idx_nxt == TOP_IDX);
         end
      end
   end

   assign bus.step_idx   = idx_q;
   assign bus.phase_inc  = inc_q;
   assign bus.step_pulse = pulse_q;
   assign bus.at_min     = min_q;
   assign bus.at_max     = max_q;

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Directed bench for freq_step_ctrl with shortened timing; expected steps go into a
// scoreboard queue and a negedge monitor checks each step_pulse against it.
module tb_freq_step_ctrl;
   localparam int D    = 4;
   localparam int RD   = 20;
   localparam int RR   = 8;
   localparam int NS   = 16;
   localparam int UNIT = 64;
   localparam int LAT  = D + 3;

   logic sysclk = 1'b0;
   logic reset  = 1'b0;

   freq_step_ctrl_if #(.STEP_W(4), .INC_W(16)) bus ();

   freq_step_ctrl #(
      .DEBOUNCE_CYC     (D),
      .REPEAT_DELAY_CYC (RD),
      .REPEAT_RATE_CYC  (RR),
      .STEP_W           (4),
      .NUM_STEPS        (NS),
      .RESET_STEP       (0),
      .INC_W            (16),
      .INC_UNIT         (UNIT)
   ) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   typedef struct {
      int edge_n;
      int idx;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_idx  = 0;

   function automatic int inc_of(input int i);
      return ((i + 1) * UNIT) % 65536;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   // Updates the step model and queues a pulse only when the step is not saturated.
   task automatic expect_step(input int at_edge, input bit up);
      exp_t e;
      if (up && m_idx < NS - 1) begin
         m_idx++;
         e.edge_n = at_edge; e.idx = m_idx; sb.push_back(e);
      end else if (!up && m_idx > 0) begin
         m_idx--;
         e.edge_n = at_edge; e.idx = m_idx; sb.push_back(e);
      end
   endtask

   task automatic tap(input bit up, input int hold);
      int t0;
      t0 = cyc;
      if (up) bus.Bt_Plus = 1'b1; else bus.Bt_Minus = 1'b1;
      expect_step(t0 + LAT, up);
      cycles(hold);
      bus.Bt_Plus  = 1'b0;
      bus.Bt_Minus = 1'b0;
      cycles(20);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_idx"},   32'(bus.step_idx),   0);
      check({tag, "_inc"},   32'(bus.phase_inc),  UNIT);
      check({tag, "_min"},   32'(bus.at_min),     1);
      check({tag, "_max"},   32'(bus.at_max),     0);
      check({tag, "_pulse"}, 32'(bus.step_pulse), 0);
   endtask

   always @(negedge sysclk) begin
      exp_t e;
      if (reset === 1'b1 && bus.step_pulse !== 1'b0) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: step_pulse=%b idx=%0d at edge %0d, none expected",
                     bus.step_pulse, bus.step_idx, cyc);
         end else begin
            e = sb.pop_front();
            check("pulse_edge", cyc, e.edge_n);
            check("pulse_idx",  32'(bus.step_idx),  e.idx);
            check("pulse_inc",  32'(bus.phase_inc), inc_of(e.idx));
            check("pulse_min",  32'(bus.at_min),    32'(e.idx == 0));
            check("pulse_max",  32'(bus.at_max),    32'(e.idx == NS - 1));
         end
      end
   end

   initial begin
      int t0;
      int t1;
      bus.Bt_Plus  = 1'b0;
      bus.Bt_Minus = 1'b0;
      reset        = 1'b0;
      cycles(2);
      check_reset_values("por");
      reset = 1'b1;
      m_idx = 0;

      // Three-cycle glitch is shorter than the debounce window.
      bus.Bt_Plus = 1'b1;
      cycles(3);
      bus.Bt_Plus = 1'b0;
      cycles(20);
      check("glitch_idx", 32'(bus.step_idx), 0);

      // Held long enough for the first step plus four repeats; released before a fifth.
      t0 = cyc;
      bus.Bt_Plus = 1'b1;
      expect_step(t0 + LAT, 1'b1);
      for (int k = 0; k < 4; k++) expect_step(t0 + LAT + RD + k * RR, 1'b1);
      cycles(50);
      bus.Bt_Plus = 1'b0;
      cycles(30);
      check("hold_idx", 32'(bus.step_idx),  5);
      check("hold_inc", 32'(bus.phase_inc), 384);

      for (int k = 0; k < 10; k++) tap(1'b1, 10);
      check("top_idx", 32'(bus.step_idx), 15);
      check("top_max", 32'(bus.at_max),   1);

      // Holding Plus at the top step: FSM runs through HOLD/REPEAT, no pulses.
      bus.Bt_Plus = 1'b1;
      cycles(30);
      check("sat_idx", 32'(bus.step_idx), 15);
      check("sat_max", 32'(bus.at_max),   1);
      check("sat_inc", 32'(bus.phase_inc), 1024);
      cycles(10);
      bus.Bt_Plus = 1'b0;
      cycles(20);

      tap(1'b0, 10);
      check("minus_idx", 32'(bus.step_idx), 14);
      check("minus_max", 32'(bus.at_max),   0);

      // Both buttons together lock out stepping until both are released.
      bus.Bt_Plus  = 1'b1;
      bus.Bt_Minus = 1'b1;
      cycles(30);
      check("lock_idx", 32'(bus.step_idx), 14);
      cycles(10);
      bus.Bt_Plus  = 1'b0;
      bus.Bt_Minus = 1'b0;
      cycles(20);
      tap(1'b1, 10);
      check("unlock_idx", 32'(bus.step_idx), 15);

      // Minus held into REPEAT, then asynchronous reset mid-cycle with the button still held.
      t0 = cyc;
      bus.Bt_Minus = 1'b1;
      expect_step(t0 + LAT, 1'b0);
      expect_step(t0 + LAT + RD, 1'b0);
      expect_step(t0 + LAT + RD + RR, 1'b0);
      cycles(38);
      check("pre_rst_idx", 32'(bus.step_idx), 12);
      #2 reset = 1'b0;
      #1 check_reset_values("arst1");
      m_idx = 0;
      cycles(2);
      reset = 1'b1;
      cycles(20);
      check("post_rst_idx", 32'(bus.step_idx), 0);
      check("post_rst_min", 32'(bus.at_min),   1);
      bus.Bt_Minus = 1'b0;
      cycles(20);

      // Same with Plus so the first post-reset step is observable.
      t0 = cyc;
      bus.Bt_Plus = 1'b1;
      expect_step(t0 + LAT, 1'b1);
      expect_step(t0 + LAT + RD, 1'b1);
      cycles(30);
      #2 reset = 1'b0;
      #1 check_reset_values("arst2");
      m_idx = 0;
      cycles(2);
      reset = 1'b1;
      t1 = cyc;
      expect_step(t1 + LAT, 1'b1);
      cycles(12);
      bus.Bt_Plus = 1'b0;
      cycles(20);
      check("rst_step_idx", 32'(bus.step_idx),  1);
      check("rst_step_inc", 32'(bus.phase_inc), 128);

      check("scoreboard_left", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
